// File: rtl/level_led_pkg.sv
// Shared encodings and helper functions for the level-progress LED driver.
package level_led_pkg;

  // Display/animation states of the LED driver.
  typedef enum logic [2:0] {
    StPlay      = 3'd0,
    StWinSweep  = 3'd1,
    StWinHold   = 3'd2,
    StFailFlash = 3'd3,
    StFailHold  = 3'd4
  } state_e;

  // ceil(log2(v)), never less than 1 so it can size a vector directly.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < {32'd0, v}) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  // Index of the highest set bit plus one; 0 when no bit is set.
  // Callers zero-extend their flag vector to 32 bits (NUM_LEVELS <= 32).
  function automatic int unsigned prio_enc(input logic [31:0] pass);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (pass[i]) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_div.sv
// Free-running divider: one-cycle tick every DIV clocks, restartable from zero.
module tick_div
  import level_led_pkg::*;
#(
  parameter int unsigned DIV = 4,
  parameter int unsigned CW  = clog2(DIV)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam logic [CW-1:0] Last = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Tick on the last count; the owner sees it in the same cycle the counter wraps.
  assign tick = (cnt_q == Last);

  // Next count: wrap on the last value, zero on restart.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart || tick) cnt_d = '0;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/level_progress_led.sv
// Level-progress LED driver: thermometer bar with a blinking in-progress LED,
// a chase animation on a win and a flash animation on a fail.
module level_progress_led
  import level_led_pkg::*;
#(
  parameter int unsigned NUM_LEVELS   = 4,
  parameter int unsigned BLINK_DIV    = 25,
  parameter int unsigned STEP_CYC     = 10,
  parameter int unsigned WIN_SWEEPS   = 2,
  parameter int unsigned FAIL_FLASHES = 3,
  localparam int unsigned LW = clog2(NUM_LEVELS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  play_en,
  input  logic [NUM_LEVELS-1:0] pass,
  input  logic                  win_pulse,
  input  logic                  fail_pulse,
  output logic [NUM_LEVELS-1:0] led,
  output logic [LW-1:0]         level_cnt,
  output logic                  anim_busy
);

  localparam int unsigned CW = clog2((BLINK_DIV > STEP_CYC) ? BLINK_DIV : STEP_CYC);
  localparam int unsigned SweepSteps = WIN_SWEEPS * NUM_LEVELS;
  localparam int unsigned FlashSteps = FAIL_FLASHES * 2;
  localparam int unsigned AW = clog2((SweepSteps > FlashSteps) ? SweepSteps : FlashSteps);
  localparam int unsigned PW = clog2(NUM_LEVELS);

  localparam logic [AW-1:0] SweepLast = AW'(SweepSteps - 1);
  localparam logic [AW-1:0] FlashLast = AW'(FlashSteps - 1);
  localparam logic [PW-1:0] PosLast   = PW'(NUM_LEVELS - 1);
  localparam logic [LW-1:0] LevelMax  = LW'(NUM_LEVELS);

  state_e                state_q, state_d;
  logic [LW-1:0]         level_q, level_d, cand;
  logic [AW-1:0]         anim_q, anim_d;
  logic [PW-1:0]         pos_q, pos_d;
  logic                  phase_q, phase_d;
  logic [NUM_LEVELS-1:0] led_q, led_d, therm;
  logic [31:0]           pass_ext;
  logic                  blink_tick, step_tick, blink_restart, step_restart;

  tick_div #(
    .DIV (BLINK_DIV),
    .CW  (CW)
  ) u_blink_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (blink_restart),
    .tick    (blink_tick)
  );

  tick_div #(
    .DIV (STEP_CYC),
    .CW  (CW)
  ) u_step_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (step_restart),
    .tick    (step_tick)
  );

  // State, level and animation-step next-state logic; clear overrides everything.
  always_comb begin
    pass_ext                 = '0;
    pass_ext[NUM_LEVELS-1:0] = pass;
    cand                     = LW'(prio_enc(pass_ext));
    state_d                  = state_q;
    level_d                  = level_q;
    anim_d                   = anim_q;
    pos_d                    = pos_q;
    case (state_q)
      StPlay: begin
        if (cand > level_q) level_d = cand;
        if (win_pulse) begin
          state_d = StWinSweep;
          level_d = LevelMax;
          anim_d  = '0;
          pos_d   = '0;
        end else if (fail_pulse) begin
          state_d = StFailFlash;
          anim_d  = '0;
        end
      end
      StWinSweep: begin
        if (step_tick) begin
          if (anim_q == SweepLast) begin
            state_d = StWinHold;
          end else begin
            anim_d = anim_q + 1'b1;
            pos_d  = (pos_q == PosLast) ? '0 : pos_q + 1'b1;
          end
        end
      end
      StFailFlash: begin
        if (step_tick) begin
          if (anim_q == FlashLast) state_d = StFailHold;
          else                     anim_d  = anim_q + 1'b1;
        end
      end
      default: ;
    endcase
    if (clear) begin
      state_d = StPlay;
      level_d = '0;
      anim_d  = '0;
      pos_d   = '0;
    end
  end

  // Divider restarts and blink phase: a level change restarts the blink with the LED off,
  // a state change aligns the animation steps to the state entry.
  always_comb begin
    blink_restart = clear || (level_d != level_q);
    step_restart  = clear || (state_d != state_q);
    phase_d       = phase_q;
    if (blink_restart)   phase_d = 1'b0;
    else if (blink_tick) phase_d = ~phase_q;
  end

  // LED pattern for the current state; registered below, so it lags the state by one cycle.
  always_comb begin
    for (int i = 0; i < NUM_LEVELS; i++) begin
      therm[i] = (LW'(i) < level_q);
    end
    led_d = '0;
    case (state_q)
      StPlay: begin
        led_d = therm;
        for (int i = 0; i < NUM_LEVELS; i++) begin
          if (play_en && (level_q < LevelMax) && (LW'(i) == level_q)) led_d[i] = phase_q;
        end
      end
      StWinSweep: begin
        for (int i = 0; i < NUM_LEVELS; i++) begin
          led_d[i] = (PW'(i) == pos_q);
        end
      end
      StWinHold:   led_d = '1;
      StFailFlash: led_d = {NUM_LEVELS{~anim_q[0]}};
      StFailHold:  led_d = therm;
      default:     led_d = '0;
    endcase
    // A new game blanks the bar on the very next cycle.
    if (clear) led_d = '0;
  end

  // State and display registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StPlay;
      level_q <= '0;
      anim_q  <= '0;
      pos_q   <= '0;
      phase_q <= 1'b0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      anim_q  <= anim_d;
      pos_q   <= pos_d;
      phase_q <= phase_d;
      led_q   <= led_d;
    end
  end

  assign led       = led_q;
  assign level_cnt = level_q;
  assign anim_busy = (state_q == StWinSweep) || (state_q == StFailFlash);

endmodule

// File: tb/tb_level_progress_led.sv
// Directed bench for level_progress_led with NUM_LEVELS=4, BLINK_DIV=4, STEP_CYC=2,
// WIN_SWEEPS=2, FAIL_FLASHES=3. Outputs are sampled 1 ns after each rising edge.
module tb_level_progress_led;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       play_en;
  logic [3:0] pass;
  logic       win_pulse;
  logic       fail_pulse;
  logic [3:0] led;
  logic [2:0] level_cnt;
  logic       anim_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  level_progress_led #(
    .NUM_LEVELS   (4),
    .BLINK_DIV    (4),
    .STEP_CYC     (2),
    .WIN_SWEEPS   (2),
    .FAIL_FLASHES (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .play_en    (play_en),
    .pass       (pass),
    .win_pulse  (win_pulse),
    .fail_pulse (fail_pulse),
    .led        (led),
    .level_cnt  (level_cnt),
    .anim_busy  (anim_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starting just after a blink restart edge: phase turns on after 4 edges and the LED
  // register shows it one edge later, so bit b is lit on samples 5..8 and dark on 9..12.
  task automatic blink_run(input string tag, input logic [3:0] base, input int b);
    logic [3:0] exp;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp = base;
      if (k >= 5 && k <= 8) exp[b] = 1'b1;
      check(tag, 32'(led), 32'(exp));
    end
  endtask

  initial begin
    logic [3:0] exp;
    rst_n      = 1'b0;
    clear      = 1'b0;
    play_en    = 1'b0;
    pass       = 4'b0000;
    win_pulse  = 1'b0;
    fail_pulse = 1'b0;

    // 1. Reset state, then blink of level 0.
    #12;
    check("reset_led", 32'(led), 32'h0);
    check("reset_level", 32'(level_cnt), 32'h0);
    check("reset_busy", 32'(anim_busy), 32'h0);
    play_en = 1'b1;
    tick();
    rst_n = 1'b1;
    blink_run("blink_l0", 4'b0000, 0);
    check("blink_l0_level", 32'(level_cnt), 32'h0);

    // 2. Jump to level 2, blink restarts dark; a lower pass does not decrease it.
    pass = 4'b0010;
    tick();
    check("pass_l2_level", 32'(level_cnt), 32'h2);
    blink_run("blink_l2", 4'b0011, 2);
    pass = 4'b0001;
    tick();
    tick();
    check("level_no_decrease", 32'(level_cnt), 32'h2);

    // 3. All levels passed: full bar, no blink.
    pass = 4'b1000;
    tick();
    check("pass_l4_level", 32'(level_cnt), 32'h4);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("full_bar_steady", 32'(led), 32'hf);
    end

    // 4. Clear, reach level 1, then win: two chase passes, then hold.
    pass  = 4'b0000;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_led", 32'(led), 32'h0);
    check("clear_level", 32'(level_cnt), 32'h0);
    pass = 4'b0001;
    tick();
    check("pass_l1_level", 32'(level_cnt), 32'h1);
    win_pulse = 1'b1;
    tick();
    win_pulse = 1'b0;
    check("win_busy", 32'(anim_busy), 32'h1);
    check("win_level_forced", 32'(level_cnt), 32'h4);
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp = 4'b0001 << (((k - 1) / 2) % 4);
      check("win_sweep", 32'(led), 32'(exp));
    end
    check("win_sweep_done_busy", 32'(anim_busy), 32'h0);
    tick();
    check("win_hold_led", 32'(led), 32'hf);
    check("win_hold_level", 32'(level_cnt), 32'h4);
    fail_pulse = 1'b1;
    tick();
    fail_pulse = 1'b0;
    tick();
    check("win_hold_ignores_fail", 32'(led), 32'hf);
    check("win_hold_busy", 32'(anim_busy), 32'h0);

    // 5. Clear, reach level 2, then fail: six flash phases, then frozen bar.
    pass  = 4'b0000;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    pass  = 4'b0010;
    tick();
    check("fail_setup_level", 32'(level_cnt), 32'h2);
    fail_pulse = 1'b1;
    tick();
    fail_pulse = 1'b0;
    check("fail_busy", 32'(anim_busy), 32'h1);
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp = ((((k - 1) / 2) % 2) == 0) ? 4'b1111 : 4'b0000;
      check("fail_flash", 32'(led), 32'(exp));
    end
    check("fail_flash_done_busy", 32'(anim_busy), 32'h0);
    tick();
    check("fail_hold_led", 32'(led), 32'h3);
    pass = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("fail_hold_frozen", 32'(led), 32'h3);
    end
    check("fail_hold_ignores_pass", 32'(level_cnt), 32'h2);

    // 6a. Clear and win in the same cycle: clear wins.
    pass      = 4'b0000;
    clear     = 1'b1;
    win_pulse = 1'b1;
    tick();
    clear     = 1'b0;
    win_pulse = 1'b0;
    check("clear_vs_win_busy", 32'(anim_busy), 32'h0);
    check("clear_vs_win_level", 32'(level_cnt), 32'h0);
    check("clear_vs_win_led", 32'(led), 32'h0);
    tick();
    check("clear_vs_win_busy_after", 32'(anim_busy), 32'h0);

    // 6b. Win and fail together: win sweep; then clear mid-sweep.
    win_pulse  = 1'b1;
    fail_pulse = 1'b1;
    tick();
    win_pulse  = 1'b0;
    fail_pulse = 1'b0;
    check("win_fail_busy", 32'(anim_busy), 32'h1);
    check("win_fail_level", 32'(level_cnt), 32'h4);
    tick();
    check("win_fail_sweep_led", 32'(led), 32'h1);
    tick();
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_mid_sweep_led", 32'(led), 32'h0);
    check("clear_mid_sweep_level", 32'(level_cnt), 32'h0);
    check("clear_mid_sweep_busy", 32'(anim_busy), 32'h0);

    // 6c. Asynchronous reset in the middle of a flash, between clock edges.
    fail_pulse = 1'b1;
    tick();
    fail_pulse = 1'b0;
    tick();
    tick();
    check("flash_before_reset", 32'(led), 32'hf);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_led", 32'(led), 32'h0);
    check("async_reset_busy", 32'(anim_busy), 32'h0);
    check("async_reset_level", 32'(level_cnt), 32'h0);
    #3;
    rst_n = 1'b1;
    tick();
    check("after_reset_busy", 32'(anim_busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
